// File: rtl/joy_sega6_reader.sv
// Dual DB9 Sega pad reader: drives the shared select line through a fixed step sequence
// and publishes active-low {M,X,Y,Z,S,A,C,B,R,L,D,U} words once per scan frame.
module joy_sega6_reader #(
  parameter int unsigned FRAME_STEPS = 256,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        step_i,
  input  logic [5:0]  joy1_i,
  input  logic [5:0]  joy2_i,
  output logic        sel_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        joy1_six_o,
  output logic        joy2_six_o,
  output logic        frame_o
);

  localparam int unsigned CntW = $clog2(FRAME_STEPS);
  localparam logic [CntW-1:0] LastStep = CntW'(FRAME_STEPS - 1);

  logic [CntW-1:0] step_q, step_d;

  logic [11:0]       sync_q [SYNC_STAGES];
  logic [1:0][5:0]   pin;

  logic              sel_q, sel_d;
  logic [1:0][11:0]  shadow_q, shadow_d;
  logic [1:0]        six_tmp_q, six_tmp_d;
  logic [1:0][11:0]  joy_q, joy_d;
  logic [1:0]        six_q, six_d;
  logic              frame_q, frame_d;

  // Pin synchronisers; reset to the idle (released) level.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= 12'hFFF;
    end else begin
      sync_q[0] <= {joy2_i, joy1_i};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign pin = sync_q[SYNC_STAGES-1];

  // Step counter state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) step_q <= '0;
    else         step_q <= step_d;
  end

  always_comb begin
    step_d = step_q;
    if (step_i) step_d = (step_q == LastStep) ? '0 : step_q + 1'b1;
  end

  // Step actions: select drive, shadow capture and atomic publish.
  always_comb begin
    sel_d     = sel_q;
    shadow_d  = shadow_q;
    six_tmp_d = six_tmp_q;
    joy_d     = joy_q;
    six_d     = six_q;
    frame_d   = 1'b0;
    if (step_i) begin
      case (step_q)
        CntW'(0): sel_d = 1'b0;
        CntW'(1): sel_d = 1'b1;
        CntW'(2): begin
          for (int p = 0; p < 2; p++) shadow_d[p][5:0] = pin[p];
          six_tmp_d = 2'b00;
          sel_d     = 1'b0;
        end
        CntW'(3): begin
          // R and L both low with select low only happens on a Mega Drive pad.
          for (int p = 0; p < 2; p++) begin
            if (pin[p][3:2] == 2'b00) shadow_d[p][7:6] = pin[p][5:4];
            else                      shadow_d[p][7:4] = {2'b11, pin[p][5:4]};
          end
          sel_d = 1'b1;
        end
        CntW'(4): sel_d = 1'b0;
        CntW'(5): begin
          for (int p = 0; p < 2; p++) begin
            six_tmp_d[p] = six_tmp_q[p] | (pin[p][3:0] == 4'h0);
          end
          sel_d = 1'b1;
        end
        CntW'(6): begin
          for (int p = 0; p < 2; p++) begin
            if (six_tmp_q[p]) shadow_d[p][11:8] = pin[p][3:0];
          end
          sel_d = 1'b0;
        end
        CntW'(7): begin
          for (int p = 0; p < 2; p++) begin
            joy_d[p] = {six_tmp_q[p] ? shadow_q[p][11:8] : 4'hF, shadow_q[p][7:0]};
          end
          six_d   = six_tmp_q;
          frame_d = 1'b1;
          sel_d   = 1'b1;
        end
        default: sel_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sel_q     <= 1'b1;
      shadow_q  <= {2{12'hFFF}};
      six_tmp_q <= 2'b00;
      joy_q     <= {2{12'hFFF}};
      six_q     <= 2'b00;
      frame_q   <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      shadow_q  <= shadow_d;
      six_tmp_q <= six_tmp_d;
      joy_q     <= joy_d;
      six_q     <= six_d;
      frame_q   <= frame_d;
    end
  end

  assign sel_o      = sel_q;
  assign joy1_o     = joy_q[0];
  assign joy2_o     = joy_q[1];
  assign joy1_six_o = six_q[0];
  assign joy2_six_o = six_q[1];
  assign frame_o    = frame_q;

endmodule

// File: tb/tb_joy_sega6_reader.sv
// Directed bench for joy_sega6_reader: behavioural Sega pad models on both ports,
// a default 256-step instance and an 8-step instance for wrap checks.
module tb_joy_sega6_reader;

  localparam logic [1:0] ModeIdle = 2'd0;
  localparam logic [1:0] ModeMs   = 2'd1;
  localparam logic [1:0] ModeMd3  = 2'd2;
  localparam logic [1:0] ModeMd6  = 2'd3;

  logic        clk = 1'b0;
  logic        reset, step, step8;
  logic [5:0]  joy1_i, joy2_i;
  logic        sel, sel8;
  logic [11:0] joy1_o, joy2_o, joy1_o8, joy2_o8;
  logic        six1, six2, six1_8, six2_8;
  logic        frame, frame8;

  logic [1:0]  mode1, mode2;
  logic [11:0] btn1, btn2;
  int          lows;
  logic        sel_prev;

  int nvec = 0;
  int nerr = 0;

  logic sel_s, frame_s, frame_s2;

  always #5 clk = ~clk;

  joy_sega6_reader dut (
    .clk_i(clk), .reset_i(reset), .step_i(step), .joy1_i(joy1_i), .joy2_i(joy2_i),
    .sel_o(sel), .joy1_o(joy1_o), .joy2_o(joy2_o), .joy1_six_o(six1), .joy2_six_o(six2),
    .frame_o(frame)
  );

  joy_sega6_reader #(.FRAME_STEPS(8), .SYNC_STAGES(2)) dut8 (
    .clk_i(clk), .reset_i(reset), .step_i(step8), .joy1_i(joy1_i), .joy2_i(joy2_i),
    .sel_o(sel8), .joy1_o(joy1_o8), .joy2_o(joy2_o8), .joy1_six_o(six1_8),
    .joy2_six_o(six2_8), .frame_o(frame8)
  );

  // Pad pins {p9,p6,R,L,D,U} from a button word {M,X,Y,Z,S,A,C,B,R,L,D,U}.
  function automatic logic [5:0] pad(input logic [1:0] mode, input logic [11:0] b,
                                     input logic s, input int nlow);
    logic [5:0] r;
    case (mode)
      ModeIdle: r = 6'h3F;
      ModeMs:   r = {b[5], b[4], b[3:0]};
      default: begin
        if (s) r = {b[5], b[4], b[3:0]};
        else   r = {b[7], b[6], 2'b00, b[1:0]};
        if (mode == ModeMd6 && nlow == 3) begin
          if (s) r = {b[5], b[4], b[11:8]};
          else   r = {b[7], b[6], 4'h0};
        end
      end
    endcase
    return r;
  endfunction

  assign joy1_i = pad(mode1, btn1, sel, lows);
  assign joy2_i = pad(mode2, btn2, sel, lows);

  // Count select low pulses since the last frame; a 6-button pad keys off the third one.
  always @(posedge clk) begin
    sel_prev <= sel;
    if (reset || frame)        lows <= 0;
    else if (sel_prev && !sel) lows <= lows + 1;
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_step();
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    sel_s   = sel;
    frame_s = frame;
    @(negedge clk) frame_s2 = frame;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input logic [11:0] e1, input logic [11:0] e2,
                           input logic es1, input logic es2);
    for (int s = 0; s < 256; s++) begin
      do_step();
      chk("sel", {11'd0, sel_s}, (s < 8) ? {11'd0, s % 2 == 1} : 12'd1);
      chk("frame", {11'd0, frame_s}, {11'd0, s == 7});
      if (s == 7) begin
        chk("frame_width", {11'd0, frame_s2}, 12'd0);
        chk("joy1", joy1_o, e1);
        chk("joy2", joy2_o, e2);
        chk("six1", {11'd0, six1}, {11'd0, es1});
        chk("six2", {11'd0, six2}, {11'd0, es2});
      end
    end
    chk("joy1_hold", joy1_o, e1);
    chk("joy2_hold", joy2_o, e2);
  endtask

  initial begin
    reset = 1'b1; step = 1'b0; step8 = 1'b0;
    mode1 = ModeIdle; mode2 = ModeIdle; btn1 = 12'hFFF; btn2 = 12'hFFF;
    lows = 0; sel_prev = 1'b1;

    // Reset, with a step pulse that must be ignored.
    repeat (3) @(negedge clk);
    step = 1'b1; step8 = 1'b1;
    @(negedge clk) step = 1'b0; step8 = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk("rst_sel", {11'd0, sel}, 12'd1);
    chk("rst_joy1", joy1_o, 12'hFFF);
    chk("rst_joy2", joy2_o, 12'hFFF);
    chk("rst_six", {10'd0, six1, six2}, 12'd0);
    chk("rst_frame", {11'd0, frame}, 12'd0);

    // Idle pads.
    repeat (3) run_frame(12'hFFF, 12'hFFF, 1'b0, 1'b0);

    // Port 1 3-button Start+B; port 2 6-button X+Up.
    mode1 = ModeMd3; btn1 = 12'hF6F;
    mode2 = ModeMd6; btn2 = 12'hBFE;
    run_frame(12'hF6F, 12'hBFE, 1'b0, 1'b1);

    // Port 1 Master System button 2; port 2 X released.
    mode1 = ModeMs; btn1 = 12'hFDF;
    btn2  = 12'hFFE;
    run_frame(12'hFDF, 12'hFFE, 1'b0, 1'b1);

    // Partial frame with X held again, reset after s4.
    btn2 = 12'hBFE;
    for (int s = 0; s < 5; s++) begin
      do_step();
      chk("partial_joy2", joy2_o, 12'hFFE);
    end
    chk("pre_rst_sel", {11'd0, sel}, 12'd0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("mid_rst_sel", {11'd0, sel}, 12'd1);
    chk("mid_rst_joy1", joy1_o, 12'hFFF);
    chk("mid_rst_joy2", joy2_o, 12'hFFF);
    chk("mid_rst_six2", {11'd0, six2}, 12'd0);
    repeat (3) @(negedge clk);
    run_frame(12'hFDF, 12'hBFE, 1'b0, 1'b1);

    // Eight-step frame, steps 5 clocks apart, across two wraps.
    mode1 = ModeIdle; mode2 = ModeIdle;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 24; s++) begin
      @(negedge clk) step8 = 1'b1;
      @(negedge clk) step8 = 1'b0;
      chk("sel8", {11'd0, sel8}, {11'd0, (s % 8) % 2 == 1});
      chk("frame8", {11'd0, frame8}, {11'd0, (s % 8) == 7});
      repeat (3) @(negedge clk);
    end
    chk("joy1_8", joy1_o8, 12'hFFF);
    chk("joy2_8", joy2_o8, 12'hFFF);
    chk("six_8", {10'd0, six1_8, six2_8}, 12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/joy_sega6_reader.md
Name: joy_sega6_reader

Overview:
- Sequences the shared select line (P7) of both DB9 joystick ports and samples them in a fixed per-frame step sequence.
- Decodes Master System, Mega Drive 3-button and Mega Drive 6-button pads on each port.
- Publishes active-low button words in MXYZ SACB RLDU order to the arcade top, replacing the hsync-driven inline reader.
- Stepping comes from a pulse input. The top drives it from a line-rate strobe.

Parameters:
- FRAME_STEPS, 256: steps per scan frame. Legal range is 8..256; the counter wraps at FRAME_STEPS-1.
- SYNC_STAGES, 2: flip-flop stages in the input synchronisers. Legal values are 2 or 3.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous active-high reset
- step_i  in  1  single-cycle step strobe; pulses at least SYNC_STAGES+2 clocks apart
- joy1_i  in  6  raw port 1 pins {p9,p6,right,left,down,up}, active-low
- joy2_i  in  6  raw port 2 pins, same format
- sel_o  out  1  P7 select drive, shared by both ports
- joy1_o  out  12  port 1 published word {M,X,Y,Z,S,A,C,B,R,L,D,U}, active-low
- joy2_o  out  12  port 2 published word, same format
- joy1_six_o  out  1  port 1 six-button pad detected in the last frame
- joy2_six_o  out  1  port 2 six-button pad detected in the last frame
- frame_o  out  1  one-cycle pulse when the published words update

Behaviour:
- Reset, one cycle with reset_i=1:
  - step counter to 0, sel_o=1;
  - shadow and published words to 12'hFFF;
  - six flags to 0, frame_o=0;
  - step_i is ignored while reset_i=1.
- Inputs pass through SYNC_STAGES flops. All "sampled" values below are synchroniser outputs.
- The action for step s executes on the clock edge where step_i=1, then the counter increments. At FRAME_STEPS-1 the counter wraps to 0.
- Step actions:
  - s0: sel_o<=0.
  - s1: sel_o<=1.
  - s2: shadow[3:0]<={R,L,D,U}; shadow[5:4]<={p9,p6}; clear six-detect temps; sel_o<=0.
  - s3: per port, if sampled R=0 and L=0 (Mega Drive pad), shadow[7:6]<={p9,p6}. Otherwise shadow[7:4]<={1,1,p9,p6}, i.e. Master System behaviour with Start/A released and C/B re-read. Then sel_o<=1.
  - s4: sel_o<=0.
  - s5: per port, if R=L=D=U=0, set six temp. Then sel_o<=1.
  - s6: per port, if six temp is set, shadow[11:8]<={R,L,D,U} (Mode,X,Y,Z). Then sel_o<=0.
  - s7: publish both ports atomically: joyN_o<=shadow, with [11:8] forced to 4'hF when six temp=0; joyN_six_o<=six temp; frame_o=1 for this cycle; sel_o<=1.
  - s8..FRAME_STEPS-1: sel_o<=1, no sampling.
- Published outputs hold their values between s7 publishes. A partial frame never reaches the outputs.
- No step_i: all state is frozen and sel_o holds its last value.
- Reset mid-frame: the rule above applies immediately. The next frame starts at s0 and publishes at the following s7.
- Ports are independent. One port can be 6-button while the other is Master System.
- Latency: a pin change is visible on joyN_o at the next s7 publish after it is sampled at s2, s3 or s6.

Test Plan:
- Idle pads (all pins 1), 3 frames → sel_o toggles 0,1,0,1,0,1,0 over s0..s6; joy1_o=joy2_o=12'hFFF; six flags 0; frame_o pulses once per frame.
- 3-button model on port 1 (sel=0 gives {Start,A,0,0,D,U}), Start and B held → joy1_o=12'hF6F (S=0, B=0); joy1_six_o=0.
- 6-button model on port 2, X and Up held, third low returns 0000 → joy2_o=12'hBFE; joy2_six_o=1. Remove X → next publish gives 12'hFFE.
- Master System model (R/L never both low), button 2 (p9) held → joy1_o=12'hFDF: bits 7:6 = 11, C=0.
- FRAME_STEPS=8, continuous steps spaced 5 clocks → frame_o every 8 steps, and the counter wraps 7→0 without a skipped sel_o toggle.
- Assert reset_i at step s4 with a 6-button pad active → outputs 12'hFFF and six=0 immediately, sel_o=1. Steps resume → correct word published 7 steps later.
